slave_rd_arb: RTL and testbench

SLAVE_RD_ARB -- requirements
Module: slave_rd_arb

---
 rtl/slave_rd_arb_pkg.sv | 49 ++++
 rtl/slave_rd_arb_order_fifo.sv | 69 ++++++
 rtl/slave_rd_arb.sv | 238 +++++++++++++++++++++++
 tb/tb_slave_rd_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_rd_arb_pkg.sv
// ----------------------------------------------------------------------------
// slave_rd_arb_pkg
// Shared types and widths for the slave read arbiter and its ordering FIFO.
//
// Width macros (normally provided by syn_tb_defines.vh):
//   `AXI_ADDR_WIDTH, `AXI_LEN_WIDTH, `AXI_SIZE_WIDTH, `WORD_SIZE
// Ordering FIFO entry layout {id, len}:
//   `ARB_ID_RANGE   bit range of the requester id inside an entry
//   `ARB_LEN_RANGE  bit range of the burst length inside an entry
// Each macro is guarded, so a project-wide syn_tb_defines.vh compiled
// earlier takes precedence over the defaults below.
// ----------------------------------------------------------------------------
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ARB_ID_WIDTH
`define ARB_ID_WIDTH 4
`endif
`ifndef ARB_LEN_RANGE
`define ARB_LEN_RANGE (`AXI_LEN_WIDTH-1):0
`endif
`ifndef ARB_ID_RANGE
`define ARB_ID_RANGE (`AXI_LEN_WIDTH+`ARB_ID_WIDTH-1):`AXI_LEN_WIDTH
`endif
`ifndef ARB_ENTRY_WIDTH
`define ARB_ENTRY_WIDTH (`AXI_LEN_WIDTH+`ARB_ID_WIDTH)
`endif

package slave_rd_arb_pkg;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_e;

   // Id field supports up to 16 requesters.
   localparam int ARB_ID_W = `ARB_ID_WIDTH;
   localparam int ENTRY_W  = `ARB_ENTRY_WIDTH;

endpackage

// File: rtl/slave_rd_arb_order_fifo.sv
// ----------------------------------------------------------------------------
// rd_order_fifo
// Response-ordering FIFO: remembers {requester id, burst len} for every
// command issued downstream, in issue order.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push / din        write an entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   dout              head entry, combinational
//   full, empty       occupancy flags (current registered occupancy)
//   count             occupancy, $clog2(DEPTH)+1 bits
// ----------------------------------------------------------------------------
module rd_order_fifo
   import slave_rd_arb_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = ENTRY_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/slave_rd_arb.sv
// ----------------------------------------------------------------------------
// slave_rd_arb
// Arbitrates NUM_REQ read requesters onto one slave2mem_rd command port and
// routes the in-order response beats back to the requester that issued each
// command. Round-robin by default; define SLAVE_RD_ARB_FIXED_PRI_EN for
// fixed priority (lowest index wins, no RR pointer).
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   req_cmd_rd/addr/len/size         per-requester packed command
//   req_grant                        one-hot accept pulse (ISSUE cycle)
//   req_rdresp_vld/data              routed response beat, 1-cycle latency
//   slave2mem_cmd_rd/addr/len/size   downstream command (pulse + held fields)
//   mem2slave_rd_ready               downstream can take a command
//   mem2slave_rdresp_vld/data        downstream response beat
//   busy                             commands outstanding
//   err_orphan                       sticky: beat arrived with nothing pending
// ----------------------------------------------------------------------------
module slave_rd_arb
   import slave_rd_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int ORD_DEPTH = 8,
   parameter int ARB_ID    = 0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  req_cmd_rd,
   input  logic [NUM_REQ*`AXI_ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*`AXI_LEN_WIDTH-1:0]   req_len,
   input  logic [NUM_REQ*`AXI_SIZE_WIDTH-1:0]  req_size,
   output logic [NUM_REQ-1:0]                  req_grant,
   output logic [NUM_REQ-1:0]                  req_rdresp_vld,
   output logic [`WORD_SIZE-1:0]               req_rdresp_data,
   output logic                                slave2mem_cmd_rd,
   output logic [`AXI_ADDR_WIDTH-1:0]          slave2mem_addr,
   output logic [`AXI_LEN_WIDTH-1:0]           slave2mem_len,
   output logic [`AXI_SIZE_WIDTH-1:0]          slave2mem_size,
   input  logic                                mem2slave_rd_ready,
   input  logic                                mem2slave_rdresp_vld,
   input  logic [`WORD_SIZE-1:0]               mem2slave_rdresp_data,
   output logic                                busy,
   output logic                                err_orphan
);

   localparam int AW = `AXI_ADDR_WIDTH;
   localparam int LW = `AXI_LEN_WIDTH;
   localparam int SW = `AXI_SIZE_WIDTH;
   localparam int CW = $clog2(ORD_DEPTH) + 1;

   arb_state_e          state_q, state_d;
   logic                arb_en;
   logic                grant_ok;
   logic [ARB_ID_W-1:0] win_id;
   logic [NUM_REQ-1:0]  win_oh;
   logic [AW-1:0]       addr_sel;
   logic [LW-1:0]       len_sel;
   logic [SW-1:0]       size_sel;

   logic [NUM_REQ-1:0]  grant_q;
   logic                cmd_rd_q;
   logic [AW-1:0]       addr_q;
   logic [LW-1:0]       len_q;
   logic [SW-1:0]       size_q;

   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0]  fifo_din, fifo_dout;
   logic [CW-1:0]       fifo_count, count_nxt;
   logic [ARB_ID_W-1:0] head_id;
   logic [LW-1:0]       head_len;
   logic                head_last;
   logic [NUM_REQ-1:0]  head_oh;
   logic [LW-1:0]       beat_cnt_q;
   logic [NUM_REQ-1:0]  rdresp_vld_q;
   logic [`WORD_SIZE-1:0] rdresp_data_q;
   logic                busy_q;
   logic                err_orphan_q;

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_ARB;
      else        state_q <= state_d;
   end

   // FSM: next state; ISSUE always lasts exactly one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ARB:   if (grant_ok) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_ARB;
         default:  state_d = ST_ARB;
      endcase
   end

   // FSM: outputs
   always_comb begin
      arb_en = (state_q == ST_ARB);
   end

   // fifo_full is the pre-pop occupancy, so a same-cycle pop never unblocks.
   assign grant_ok = arb_en && (|req_cmd_rd) && mem2slave_rd_ready && !fifo_full;

`ifndef SLAVE_RD_ARB_FIXED_PRI_EN
   // Points at the requester after the last winner.
   logic [ARB_ID_W-1:0] rr_ptr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rr_ptr_q <= '0;
      else if (grant_ok)
         rr_ptr_q <= (win_id == ARB_ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
   end
`endif

   always_comb begin
      win_id = '0;
`ifdef SLAVE_RD_ARB_FIXED_PRI_EN
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (req_cmd_rd[i]) win_id = ARB_ID_W'(i);
      end
`else
      begin : rr_search
         logic found;
         found = 1'b0;
         for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (!found && req_cmd_rd[i] && (i == (int'(rr_ptr_q) + k) % NUM_REQ)) begin
                  found  = 1'b1;
                  win_id = ARB_ID_W'(i);
               end
            end
         end
      end
`endif
   end

   always_comb begin
      win_oh   = '0;
      addr_sel = '0;
      len_sel  = '0;
      size_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == ARB_ID_W'(i)) begin
            win_oh[i] = 1'b1;
            addr_sel  = req_addr[i*AW +: AW];
            len_sel   = req_len[i*LW +: LW];
            size_sel  = req_size[i*SW +: SW];
         end
      end
   end

   // Command fields hold the last granted command between grants.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_q  <= '0;
         cmd_rd_q <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
      end else begin
         grant_q  <= grant_ok ? win_oh : '0;
         cmd_rd_q <= grant_ok;
         if (grant_ok) begin
            addr_q <= addr_sel;
            len_q  <= len_sel;
            size_q <= size_sel;
         end
      end
   end

   assign fifo_push = grant_ok;
   assign fifo_din  = {win_id, len_sel};

   rd_order_fifo #(
      .DEPTH (ORD_DEPTH),
      .W     (ENTRY_W)
   ) u_order_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_id   = fifo_dout[`ARB_ID_RANGE];
   assign head_len  = fifo_dout[`ARB_LEN_RANGE];
   assign head_last = (beat_cnt_q == head_len);
   assign fifo_pop  = mem2slave_rdresp_vld && !fifo_empty && head_last;

   always_comb begin
      head_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (head_id == ARB_ID_W'(i)) head_oh[i] = 1'b1;
      end
   end

   // Push is only taken when not full and pop only when not empty.
   assign count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt_q    <= '0;
         rdresp_vld_q  <= '0;
         rdresp_data_q <= '0;
         busy_q        <= 1'b0;
         err_orphan_q  <= 1'b0;
      end else begin
         rdresp_vld_q <= '0;
         busy_q       <= (count_nxt != '0);
         if (mem2slave_rdresp_vld) begin
            rdresp_data_q <= mem2slave_rdresp_data;
            if (fifo_empty) begin
               err_orphan_q <= 1'b1;
`ifndef SYNTHESIS
               $display("slave_rd_arb[%0d] orphan response beat dropped, ordering FIFO empty", ARB_ID);
`endif
            end else begin
               rdresp_vld_q <= head_oh;
               beat_cnt_q   <= head_last ? '0 : beat_cnt_q + 1'b1;
            end
         end
      end
   end

   assign req_grant        = grant_q;
   assign slave2mem_cmd_rd = cmd_rd_q;
   assign slave2mem_addr   = addr_q;
   assign slave2mem_len    = len_q;
   assign slave2mem_size   = size_q;
   assign req_rdresp_vld   = rdresp_vld_q;
   assign req_rdresp_data  = rdresp_data_q;
   assign busy             = busy_q;
   assign err_orphan       = err_orphan_q;

endmodule

// File: tb/tb_slave_rd_arb.sv
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_slave_rd_arb;

   localparam int NR = 2;
   localparam int AW = `AXI_ADDR_WIDTH;
   localparam int LW = `AXI_LEN_WIDTH;
   localparam int SW = `AXI_SIZE_WIDTH;
   localparam int DW = `WORD_SIZE;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_cmd_rd;
   logic [NR*AW-1:0] req_addr;
   logic [NR*LW-1:0] req_len;
   logic [NR*SW-1:0] req_size;
   logic [NR-1:0]    req_grant;
   logic [NR-1:0]    req_rdresp_vld;
   logic [DW-1:0]    req_rdresp_data;
   logic             slave2mem_cmd_rd;
   logic [AW-1:0]    slave2mem_addr;
   logic [LW-1:0]    slave2mem_len;
   logic [SW-1:0]    slave2mem_size;
   logic             mem2slave_rd_ready;
   logic             mem2slave_rdresp_vld;
   logic [DW-1:0]    mem2slave_rdresp_data;
   logic             busy;
   logic             err_orphan;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   slave_rd_arb #(
      .NUM_REQ   (NR),
      .ORD_DEPTH (8),
      .ARB_ID    (0)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .req_cmd_rd            (req_cmd_rd),
      .req_addr              (req_addr),
      .req_len               (req_len),
      .req_size              (req_size),
      .req_grant             (req_grant),
      .req_rdresp_vld        (req_rdresp_vld),
      .req_rdresp_data       (req_rdresp_data),
      .slave2mem_cmd_rd      (slave2mem_cmd_rd),
      .slave2mem_addr        (slave2mem_addr),
      .slave2mem_len         (slave2mem_len),
      .slave2mem_size        (slave2mem_size),
      .mem2slave_rd_ready    (mem2slave_rd_ready),
      .mem2slave_rdresp_vld  (mem2slave_rdresp_vld),
      .mem2slave_rdresp_data (mem2slave_rdresp_data),
      .busy                  (busy),
      .err_orphan            (err_orphan)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   logic [NR-1:0] exp_g [4];

   initial begin
`ifdef SLAVE_RD_ARB_FIXED_PRI_EN
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`else
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`endif
      reset                 = 1'b0;
      req_cmd_rd            = '0;
      req_addr              = '0;
      req_len               = '0;
      req_size              = '0;
      mem2slave_rd_ready    = 1'b0;
      mem2slave_rdresp_vld  = 1'b0;
      mem2slave_rdresp_data = '0;
      step(); step(); step();

      // Reset state
      chk("rst_grant", 64'(req_grant), 64'h0);
      chk("rst_cmd_rd", 64'(slave2mem_cmd_rd), 64'h0);
      chk("rst_rdresp_vld", 64'(req_rdresp_vld), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_err", 64'(err_orphan), 64'h0);
      chk("rst_addr", 64'(slave2mem_addr), 64'h0);
      chk("rst_data", 64'(req_rdresp_data), 64'h0);
      reset = 1'b1;
      step();

      // Single command from requester 1, len=3
      req_addr[AW +: AW] = 32'h1000_0040;
      req_len[LW +: LW]  = 8'd3;
      req_size[SW +: SW] = 3'd2;
      req_cmd_rd         = 2'b10;
      mem2slave_rd_ready = 1'b1;
      step();
      chk("t1_grant", 64'(req_grant), 64'h2);
      chk("t1_cmd_rd", 64'(slave2mem_cmd_rd), 64'h1);
      chk("t1_addr", 64'(slave2mem_addr), 64'h1000_0040);
      chk("t1_len", 64'(slave2mem_len), 64'h3);
      chk("t1_size", 64'(slave2mem_size), 64'h2);
      chk("t1_busy", 64'(busy), 64'h1);
      req_cmd_rd = 2'b00;
      step();
      chk("t1_grant_off", 64'(req_grant), 64'h0);
      chk("t1_cmd_rd_off", 64'(slave2mem_cmd_rd), 64'h0);
      chk("t1_addr_hold", 64'(slave2mem_addr), 64'h1000_0040);
      for (int b = 0; b < 4; b++) begin
         mem2slave_rdresp_vld  = 1'b1;
         mem2slave_rdresp_data = 32'hA0 + 32'(b);
         step();
         chk("t1_beat_vld", 64'(req_rdresp_vld), 64'h2);
         chk("t1_beat_data", 64'(req_rdresp_data), 64'hA0 + 64'(b));
         chk("t1_busy_beat", 64'(busy), (b == 3) ? 64'h0 : 64'h1);
      end
      mem2slave_rdresp_vld = 1'b0;
      step();
      chk("t1_vld_off", 64'(req_rdresp_vld), 64'h0);

      // Both requesters held from reset
      reset      = 1'b0;
      req_len    = '0;
      req_cmd_rd = 2'b11;
      step();
      reset = 1'b1;
      for (int g = 0; g < 4; g++) begin
         step();
         chk("t2_grant", 64'(req_grant), 64'(exp_g[g]));
         step();
         chk("t2_gap", 64'(req_grant), 64'h0);
      end
      req_cmd_rd           = 2'b00;
      mem2slave_rdresp_vld = 1'b1;
      for (int g = 0; g < 4; g++) begin
         step();
         chk("t2_route", 64'(req_rdresp_vld), 64'(exp_g[g]));
      end
      mem2slave_rdresp_vld = 1'b0;
      step();
      chk("t2_busy", 64'(busy), 64'h0);

      // Downstream not ready for 10 cycles
      mem2slave_rd_ready = 1'b0;
      req_cmd_rd         = 2'b01;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("t3_no_grant", 64'(req_grant), 64'h0);
      end
      mem2slave_rd_ready = 1'b1;
      step();
      chk("t3_grant", 64'(req_grant), 64'h1);
      req_cmd_rd = 2'b00;
      step();
      mem2slave_rdresp_vld = 1'b1;
      step();
      mem2slave_rdresp_vld = 1'b0;
      chk("t3_busy", 64'(busy), 64'h0);

      // Fill the ordering FIFO with eight len=0 commands
      req_cmd_rd = 2'b01;
      for (int g = 0; g < 8; g++) begin
         step();
         chk("t4_grant", 64'(req_grant), 64'h1);
         step();
         chk("t4_gap", 64'(req_grant), 64'h0);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t4_stall", 64'(req_grant), 64'h0);
      end
      mem2slave_rdresp_vld = 1'b1;
      step();
      mem2slave_rdresp_vld = 1'b0;
      chk("t4_pop_no_grant", 64'(req_grant), 64'h0);
      chk("t4_pop_vld", 64'(req_rdresp_vld), 64'h1);
      step();
      chk("t4_grant_after_pop", 64'(req_grant), 64'h1);
      req_cmd_rd = 2'b00;
      step();
      chk("t4_busy_full", 64'(busy), 64'h1);
      mem2slave_rdresp_vld = 1'b1;
      for (int b = 0; b < 8; b++) begin
         step();
         chk("t4_drain_vld", 64'(req_rdresp_vld), 64'h1);
      end
      mem2slave_rdresp_vld = 1'b0;
      chk("t4_busy_empty", 64'(busy), 64'h0);
      step();

      // Orphan beat at idle
      mem2slave_rdresp_vld = 1'b1;
      step();
      mem2slave_rdresp_vld = 1'b0;
      chk("t5_err", 64'(err_orphan), 64'h1);
      chk("t5_no_vld", 64'(req_rdresp_vld), 64'h0);
      step(); step(); step();
      chk("t5_err_sticky", 64'(err_orphan), 64'h1);

      // Reset after 2 of 4 beats
      req_addr[AW +: AW] = 32'h2000_0080;
      req_len[LW +: LW]  = 8'd3;
      req_cmd_rd         = 2'b10;
      step();
      chk("t6_grant", 64'(req_grant), 64'h2);
      req_cmd_rd = 2'b00;
      step();
      mem2slave_rdresp_vld  = 1'b1;
      mem2slave_rdresp_data = 32'h55;
      step();
      mem2slave_rdresp_data = 32'h66;
      step();
      mem2slave_rdresp_vld = 1'b0;
      chk("t6_mid_vld", 64'(req_rdresp_vld), 64'h2);
      chk("t6_mid_data", 64'(req_rdresp_data), 64'h66);
      reset = 1'b0;
      #1;
      chk("t6_async_vld", 64'(req_rdresp_vld), 64'h0);
      chk("t6_async_data", 64'(req_rdresp_data), 64'h0);
      chk("t6_async_busy", 64'(busy), 64'h0);
      chk("t6_async_err", 64'(err_orphan), 64'h0);
      chk("t6_async_addr", 64'(slave2mem_addr), 64'h0);
      step();
      reset = 1'b1;
      step();
      chk("t6_busy_after", 64'(busy), 64'h0);
      mem2slave_rdresp_vld = 1'b1;
      step();
      mem2slave_rdresp_vld = 1'b0;
      chk("t6_discarded_vld", 64'(req_rdresp_vld), 64'h0);
      chk("t6_discarded_err", 64'(err_orphan), 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
